// File: rtl/kbd_tx_pkg.sv
// Shared definitions for the keyboard-to-uart transmit buffer: issue FSM
// state encoding, ASCII control codes and the CR->LF expansion decision.
package kbd_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // True when the byte just sent is a CR whose trailing LF is still owed.
    function automatic logic needs_lf(input logic expand, input logic [7:0] data,
                                      input logic lf_done);
        return expand && (data == ASCII_CR) && !lf_done;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags. The caller guarantees
// that push is never asserted while full and pop never while empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    // Next pointer and occupancy values; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW + 1)'(DEPTH));
        empty_d = (count_d == (AW + 1)'(0));
    end

    // Storage array; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW + 1)'(0);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/kbd_tx_fifo.sv
// Elastic buffer between the keyboard byte strobe and the uart transmitter.
// Bytes are issued one at a time using the uart busy handshake; a CR can be
// followed by an inserted LF. Any dropped keystroke sets a sticky overflow.
module kbd_tx_fifo
    import kbd_tx_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CRLF_EXPAND  = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   overflow_clr
);
    localparam int             TW         = $clog2(BUSY_TIMEOUT);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic           CRLF_ON    = (CRLF_EXPAND != 32'sd0);

    logic        push_s, pop_s, drop_s;
    logic [7:0]  head_s;
    logic        fifo_full_s, fifo_empty_s;

    tx_state_e     state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          lf_done_q, lf_done_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          overflow_q, overflow_d;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .wr_data (in_data),
        .pop     (pop_s),
        .rd_data (head_s),
        .count   (count),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Accept or drop incoming bytes using the pre-edge full flag; a drop wins over clear.
    always_comb begin
        push_s = in_valid && !fifo_full_s;
        drop_s = in_valid && fifo_full_s;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Issue FSM: pop, strobe, wait for busy (or time out), wait for idle, optional LF.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        lf_done_d = lf_done_q;
        timer_d   = timer_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && !tx_busy) begin
                    pop_s     = 1'b1;
                    tx_data_d = head_s;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_d = TW'(0);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (needs_lf(CRLF_ON, tx_data_q, lf_done_q)) begin
                        tx_data_d = ASCII_LF;
                        lf_done_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end else begin
                        lf_done_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                lf_done_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        tx_valid_d = (state_d == ST_ISSUE);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            lf_done_q  <= 1'b0;
            timer_q    <= TW'(0);
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            lf_done_q  <= lf_done_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign full     = fifo_full_s;
    assign empty    = fifo_empty_s;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_kbd_tx_fifo.sv
// Bench for kbd_tx_fifo: one instance with CR->LF expansion, one without,
// sharing stimulus. A uart responder model drives busy per instance and a
// scoreboard queue per instance holds the bytes expected on tx.
module tb_kbd_tx_fifo;
    localparam int DEPTH = 16;
    localparam int BT    = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       overflow_clr;
    logic       force_busy;
    logic [1:0] busy_m;
    logic [1:0] tx_busy_v;
    logic [1:0] tx_valid_v;
    logic [7:0] tx_data_a, tx_data_b;
    logic [4:0] count_a, count_b;
    logic [1:0] full_v, empty_v, ovf_v;

    assign tx_busy_v = busy_m | {2{force_busy}};

    kbd_tx_fifo #(.DEPTH(DEPTH), .CRLF_EXPAND(1), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .tx_data(tx_data_a), .tx_valid(tx_valid_v[0]), .tx_busy(tx_busy_v[0]),
        .count(count_a), .full(full_v[0]), .empty(empty_v[0]),
        .overflow(ovf_v[0]), .overflow_clr(overflow_clr));

    kbd_tx_fifo #(.DEPTH(DEPTH), .CRLF_EXPAND(0), .BUSY_TIMEOUT(BT)) dut_nolf (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .tx_data(tx_data_b), .tx_valid(tx_valid_v[1]), .tx_busy(tx_busy_v[1]),
        .count(count_b), .full(full_v[1]), .empty(empty_v[1]),
        .overflow(ovf_v[1]), .overflow_clr(overflow_clr));

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       clr;
        logic       kept;
        logic [4:0] cnt;
        logic       fl;
        logic       ov;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         dly[2];
    int         hold[2];
    int         hold_len;
    bit         resp_en;
    int         cyc = 0;
    int         last_v = 0;
    int         prev_v = 0;
    int         vcnt_a = 0;
    int         vcnt_b = 0;
    vec_t       vt[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor plus uart busy responder, evaluated on the falling edge.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (tx_valid_v[0]) begin
                    vcnt_a++;
                    prev_v = last_v;
                    last_v = cyc;
                    if (exp_a.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL tx_a_extra: got byte %0h, required no transfer", tx_data_a);
                    end else begin
                        check("tx_a_data", tx_data_a, exp_a.pop_front());
                    end
                end
                if (tx_valid_v[1]) begin
                    vcnt_b++;
                    if (exp_b.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL tx_b_extra: got byte %0h, required no transfer", tx_data_b);
                    end else begin
                        check("tx_b_data", tx_data_b, exp_b.pop_front());
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    dly[i] = 0; hold[i] = 0; busy_m[i] = 1'b0;
                end else begin
                    if (hold[i] > 0) begin
                        hold[i]--;
                        if (hold[i] == 0) busy_m[i] = 1'b0;
                    end else if (dly[i] > 0) begin
                        dly[i]--;
                        if (dly[i] == 0) begin busy_m[i] = 1'b1; hold[i] = hold_len; end
                    end
                    if (tx_valid_v[i] && resp_en) dly[i] = 2;
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] d, input bit kept);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        if (kept) begin
            exp_a.push_back(d);
            if (d == 8'h0D) exp_a.push_back(8'h0A);
            exp_b.push_back(d);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        in_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_a.size() == 0 && exp_b.size() == 0) break;
        end
        repeat (40) @(negedge clk);
        check(name, exp_a.size() + exp_b.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; overflow_clr = 1'b0; force_busy = 1'b0;
        exp_a.delete(); exp_b.delete();
        @(negedge clk);
        check("rst_count", count_a, 0);
        check("rst_empty", empty_v[0], 1);
        check("rst_full", full_v[0], 0);
        check("rst_overflow", ovf_v[0], 0);
        check("rst_tx_valid", tx_valid_v, 0);
        check("rst_tx_data", tx_data_a, 0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0, v1, gap;
        reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; overflow_clr = 1'b0;
        force_busy = 1'b0; busy_m = 2'b00; resp_en = 1'b1; hold_len = 20;
        fork monitor_loop(); join_none
        do_reset();

        // Single byte: latency N+2, count 1 -> 0.
        v0 = vcnt_a;
        push(8'h41, 1'b1);
        idle();
        check("t1_valid_n1", tx_valid_v[0], 0);
        check("t1_count_n1", count_a, 1);
        check("t1_empty_n1", empty_v[0], 0);
        @(negedge clk);
        check("t1_valid_n2", tx_valid_v[0], 1);
        check("t1_data_n2", tx_data_a, 8'h41);
        check("t1_count_n2", count_a, 0);
        check("t1_empty_n2", empty_v[0], 1);
        drain("t1_drain", 200);
        check("t1_one_pulse", vcnt_a - v0, 1);

        // Fill with uart busy, overflow drop and clear interplay.
        for (int i = 0; i < 16; i++)
            vt[i] = '{1'b1, 8'h30 + 8'(i), 1'b0, 1'b1, 5'(i + 1), (i == 15), 1'b0};
        vt[16] = '{1'b1, 8'hEE, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1};
        vt[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0};
        vt[18] = '{1'b1, 8'hEF, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1};
        vt[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1};
        vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0};
        hold_len = 3;
        force_busy = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            in_data = vt[i].d; in_valid = vt[i].iv; overflow_clr = vt[i].clr;
            if (vt[i].kept) begin exp_a.push_back(vt[i].d); exp_b.push_back(vt[i].d); end
            @(posedge clk); #1;
            in_valid = 1'b0; overflow_clr = 1'b0;
            check($sformatf("vec%0d_count", i), count_a, vt[i].cnt);
            check($sformatf("vec%0d_full", i), full_v[0], vt[i].fl);
            check($sformatf("vec%0d_empty", i), empty_v[0], (vt[i].cnt == 5'd0));
            check($sformatf("vec%0d_overflow", i), ovf_v[0], vt[i].ov);
        end
        force_busy = 1'b0;
        drain("t2_drain", 2000);
        check("t2_empty_after", empty_v[0], 1);
        check("t2_count_after", count_a, 0);

        // CR expansion versus pass-through.
        v0 = vcnt_a; v1 = vcnt_b;
        push(8'h0D, 1'b1);
        push(8'h62, 1'b1);
        idle();
        drain("t4_drain", 500);
        check("t4_count_crlf", vcnt_a - v0, 3);
        check("t4_count_plain", vcnt_b - v1, 2);

        // No busy response: each byte released by the timeout.
        resp_en = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        idle();
        drain("t5_drain", 500);
        gap = last_v - prev_v;
        check("t5_timeout_gap", gap, BT + 3);
        resp_en = 1'b1;

        // Reset while waiting for busy to fall with bytes queued.
        hold_len = 30;
        for (int i = 0; i < 6; i++) push(8'h61 + 8'(i), 1'b1);
        idle();
        for (int i = 0; i < 50; i++) begin
            if (busy_m[0]) break;
            @(negedge clk);
        end
        check("t6_busy_seen", busy_m[0], 1);
        repeat (2) @(negedge clk);
        check("t6_count_before", count_a, 5);
        #2 reset = 1'b1;
        exp_a.delete(); exp_b.delete();
        #1;
        check("t6_tx_valid", tx_valid_v[0], 0);
        check("t6_tx_data", tx_data_a, 0);
        check("t6_count", count_a, 0);
        check("t6_empty", empty_v[0], 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold_len = 3;
        v0 = vcnt_a;
        push(8'h7A, 1'b1);
        idle();
        drain("t6_drain", 300);
        check("t6_after_pulse", vcnt_a - v0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
